fetch_unit: RTL

- Instruction-fetch stage sitting directly upstream of decode/execute.
- Owns the architectural PC and issues one-at-a-time word fetches over a req/ack memory handshake.
- Hands each fetched instruction to decode with a valid/ready handshake.
- Consumes the redirect (valid, jump_pc, pc_out) produced by execute_jump. Squashes in-flight or held work on redirect and flags misaligned jump targets.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// EXC_INST_ADDR_MISALIGNED uses the same cause numbering as execute_jump.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

  localparam int unsigned INST_BYTES = 4;
  localparam logic [5:0] EXC_INST_ADDR_MISALIGNED = 6'd0;

endpackage

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single outstanding word fetches,
// holds one instruction for decode and applies execute redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exec_valid,
  input  logic        exec_jump_pc,
  input  logic [31:0] exec_pc_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        decode_valid,
  input  logic        decode_ready,
  output logic [31:0] decode_inst,
  output logic [31:0] decode_pc,
  output logic [5:0]  exception_num_out,
  output logic        exception_valid_out
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic         r_squash;
  logic         r_mem_req;
  logic [31:0]  r_mem_addr;
  logic         r_dec_valid;
  logic [31:0]  r_dec_inst;
  logic [31:0]  r_dec_pc;
  logic         r_exc_valid;
  logic [5:0]   r_exc_num;

  logic         w_redir;
  logic         w_aligned;
  logic         w_busy;
  logic [31:0]  w_pc_inc;

  assign w_redir   = exec_valid & exec_jump_pc;
  assign w_aligned = (exec_pc_out[1:0] == 2'b00);
  // A request is still outstanding after this cycle unless it is acked now.
  assign w_busy    = r_mem_req & ~mem_ack;
  assign w_pc_inc  = r_pc + 32'(INST_BYTES);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_squash    <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= 32'h0;
      r_dec_valid <= 1'b0;
      r_dec_inst  <= 32'h0;
      r_dec_pc    <= 32'h0;
      r_exc_valid <= 1'b0;
      r_exc_num   <= 6'd0;
    end else if (w_redir) begin
      r_dec_valid <= 1'b0;
      if (w_aligned) begin
        r_pc        <= exec_pc_out;
        r_state     <= REQ;
        r_exc_valid <= 1'b0;
        if (w_busy) begin
          // Old address stays on the bus; its data is dropped when acked.
          r_squash <= 1'b1;
        end else begin
          r_squash   <= 1'b0;
          r_mem_req  <= 1'b1;
          r_mem_addr <= exec_pc_out;
        end
      end else begin
        r_state     <= FAULT;
        r_exc_valid <= 1'b1;
        r_exc_num   <= EXC_INST_ADDR_MISALIGNED;
        r_squash    <= 1'b0;
        if (!w_busy) r_mem_req <= 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          r_state    <= REQ;
          r_mem_req  <= 1'b1;
          r_mem_addr <= r_pc;
        end
        REQ: begin
          if (r_mem_req && mem_ack) begin
            if (r_squash) begin
              r_squash   <= 1'b0;
              r_mem_addr <= r_pc;
            end else begin
              r_mem_req   <= 1'b0;
              r_dec_valid <= 1'b1;
              r_dec_inst  <= mem_data;
              r_dec_pc    <= r_pc;
              r_state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (decode_ready) begin
            r_dec_valid <= 1'b0;
            r_pc        <= w_pc_inc;
            r_mem_req   <= 1'b1;
            r_mem_addr  <= w_pc_inc;
            r_state     <= REQ;
          end
        end
        FAULT: begin
          if (r_mem_req && mem_ack) begin
            r_mem_req <= 1'b0;
            r_squash  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req             = r_mem_req;
  assign mem_addr            = r_mem_addr;
  assign decode_valid        = r_dec_valid;
  assign decode_inst         = r_dec_inst;
  assign decode_pc           = r_dec_pc;
  assign exception_valid_out = r_exc_valid;
  assign exception_num_out   = r_exc_num;

endmodule
